pixel_write_queue: RTL and testbench

//  Downstream of the datapath ALU. Takes pixel store requests (x/y from the ALU's
//  320/240 wrap-increment modes, plus a colour word), range-checks them and forms
//  the framebuffer address FB_BASE + y*H_RES + x. Buffers them in a FIFO toward the

---
 rtl/gpu_pkg.sv | 19 +
 rtl/pwq_fifo.sv | 56 +++++
 rtl/pixel_write_queue.sv | 169 ++++++++++++++++
 tb/tb_pixel_write_queue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared GPU geometry, memory width and pixel-write types.
// Used by the ALU and by pixel_write_queue and its FIFO.
package gpu_pkg;

  localparam int H_RES  = 320;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 20;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } pix_req_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } pwq_state_e;

endpackage

// File: rtl/pwq_fifo.sv
// pwq_fifo: synchronous DEPTH-entry FIFO of request words.
// Ports: push/din, pop/dout (show-ahead head), count, full, empty.
module pwq_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = gpu_pkg::pix_req_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a write when it is popped in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: range-checks pixel stores, forms FB address, queues them
// to the SRAM arbiter and reports frame retirement. Ports: wr_* request in,
// mem_* head out, frame_done/frame_flushed, err_* flags, drop_count.
// Build option PWQ_DROP_CNT_EN enables the saturating drop counter.
module pixel_write_queue #(
  parameter int                H_RES   = gpu_pkg::H_RES,
  parameter int                V_RES   = gpu_pkg::V_RES,
  parameter int                DEPTH   = 8,
  parameter int                ADDR_W  = gpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_x,
  input  logic [15:0]       wr_y,
  input  logic [15:0]       wr_color,
  input  logic              frame_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              frame_flushed,
  input  logic              err_clr,
  output logic              err_oob,
  output logic              err_frame_ovr,
  output logic [15:0]       drop_count
);

  import gpu_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } req_t;

  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  logic           acc;
  logic           in_rng;
  logic           acc_in;
  logic           acc_oob;
  logic           pop;
  logic           push;
  logic           stg_valid;
  req_t           stg_req;
  req_t           head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  pend;
  logic [CW-1:0]  pend_nxt;
  logic [CW1-1:0] pend_load;
  pwq_state_e     state;
  pwq_state_e     state_nxt;

  assign in_rng = (wr_x < 16'(H_RES)) && (wr_y < 16'(V_RES));

  // counts the address stage so it can always drain into the FIFO
  assign wr_ready = (CW1'(fifo_count) + CW1'(stg_valid)) < CW1'(DEPTH);

  assign acc     = wr_valid & wr_ready;
  assign acc_in  = acc & in_rng;
  assign acc_oob = acc & ~in_rng;
  assign pop     = mem_valid & mem_ready;
  assign push    = stg_valid & (~fifo_full | pop);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stg_valid <= 1'b0;
      stg_req   <= '0;
    end else begin
      stg_valid <= acc_in;
      if (acc_in) begin
        stg_req.addr <= FB_BASE
                      + ADDR_W'(wr_y) * ADDR_W'(H_RES)
                      + ADDR_W'(wr_x);
        stg_req.data <= wr_color;
      end
    end
  end

  pwq_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push),
    .din   (stg_req),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_valid = ~fifo_empty;
  assign mem_addr  = mem_valid ? head.addr : '0;
  assign mem_data  = mem_valid ? head.data : '0;

  // writes ahead of the marker: queued, staged, accepted now, minus a pop now
  assign pend_load = CW1'(fifo_count) + CW1'(stg_valid)
                   + CW1'(acc_in) - CW1'(pop);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    frame_flushed = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_done) begin
          state_nxt = DRAIN;
          pend_nxt  = CW'(pend_load);
        end
      end
      DRAIN: begin
        if (pend == '0) begin
          frame_flushed = 1'b1;
          state_nxt     = IDLE;
        end else if (pop) begin
          pend_nxt = pend - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_oob       <= 1'b0;
      err_frame_ovr <= 1'b0;
    end else begin
      if (acc_oob)      err_oob <= 1'b1;
      else if (err_clr) err_oob <= 1'b0;
      if (frame_done && state == DRAIN) err_frame_ovr <= 1'b1;
      else if (err_clr)                 err_frame_ovr <= 1'b0;
    end
  end

`ifdef PWQ_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drop_q <= '0;
    end else if (acc_oob && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb_pixel_write_queue: directed self-checking bench for pixel_write_queue.
// One task per scenario; summary line at the end.
module tb_pixel_write_queue;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_x = '0;
  logic [15:0] wr_y = '0;
  logic [15:0] wr_color = '0;
  logic        frame_done = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [19:0] mem_addr;
  logic [15:0] mem_data;
  logic        frame_flushed;
  logic        err_clr = 1'b0;
  logic        err_oob;
  logic        err_frame_ovr;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

`ifdef PWQ_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  always #5 Clk = ~Clk;

  pixel_write_queue dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_color      (wr_color),
    .frame_done    (frame_done),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .frame_flushed (frame_flushed),
    .err_clr       (err_clr),
    .err_oob       (err_oob),
    .err_frame_ovr (err_frame_ovr),
    .drop_count    (drop_count)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    #2;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b exp 0", mem_valid); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL rst_flushed got %b exp 0", frame_flushed); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL rst_err_oob got %b exp 0", err_oob); end
    checks++; if (err_frame_ovr !== 1'b0) begin errors++; $display("FAIL rst_err_ovr got %b exp 0", err_frame_ovr); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rst_drop got %h exp 0", drop_count); end
    checks++; if (mem_addr !== 20'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    tick;
    tick;
    Reset_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    mem_ready = 1'b1;
    wr_valid = 1'b1; wr_x = 16'd5; wr_y = 16'd2; wr_color = 16'hABCD;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", wr_ready); end
    tick;
    wr_valid = 1'b0;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_n1_valid got %b exp 0", mem_valid); end
    tick;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_n2_valid got %b exp 1", mem_valid); end
    checks++; if (mem_addr !== 20'd645) begin errors++; $display("FAIL single_addr got %0d exp 645", mem_addr); end
    checks++; if (mem_data !== 16'hABCD) begin errors++; $display("FAIL single_data got %h exp abcd", mem_data); end
    tick;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_one_beat got %b exp 0", mem_valid); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    int beats = 0;
    mem_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      wr_valid = 1'b1; wr_x = 16'(acc); wr_y = 16'd1; wr_color = 16'h1000 + 16'(acc);
      if (wr_ready) acc++;
      tick;
    end
    wr_valid = 1'b0;
    checks++; if (acc != 8) begin errors++; $display("FAIL bp_accepted got %0d exp 8", acc); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", wr_ready); end
    checks++; if (mem_addr !== 20'd320) begin errors++; $display("FAIL bp_head got %0d exp 320", mem_addr); end
    tick;
    tick;
    checks++; if (mem_addr !== 20'd320) begin errors++; $display("FAIL bp_head_stable got %0d exp 320", mem_addr); end
    checks++; if (mem_data !== 16'h1000) begin errors++; $display("FAIL bp_head_data got %h exp 1000", mem_data); end
    mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (mem_valid) begin
        checks++; if (mem_addr !== 20'(320 + beats)) begin errors++; $display("FAIL bp_beat%0d addr got %0d exp %0d", beats, mem_addr, 320 + beats); end
        checks++; if (mem_data !== 16'h1000 + 16'(beats)) begin errors++; $display("FAIL bp_beat%0d data got %h", beats, mem_data); end
        beats++;
      end
      if (acc < 10) begin
        wr_valid = 1'b1; wr_x = 16'(acc); wr_y = 16'd1; wr_color = 16'h1000 + 16'(acc);
        if (wr_ready) acc++;
      end else begin
        wr_valid = 1'b0;
      end
      tick;
    end
    wr_valid = 1'b0;
    checks++; if (beats != 10) begin errors++; $display("FAIL bp_beats got %0d exp 10", beats); end
    checks++; if (acc != 10) begin errors++; $display("FAIL bp_all_acc got %0d exp 10", acc); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", wr_ready); end
  endtask

  task automatic test_oob;
    int beats = 0;
    mem_ready = 1'b1;
    wr_valid = 1'b1; wr_x = 16'd320; wr_y = 16'd0;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready got %b exp 1", wr_ready); end
    tick;
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_flag_n1 got %b exp 1", err_oob); end
    wr_x = 16'd0; wr_y = 16'd240;
    tick;
    wr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (mem_valid) beats++;
      tick;
    end
    checks++; if (beats != 0) begin errors++; $display("FAIL oob_no_beats got %0d exp 0", beats); end
    checks++; if (drop_count !== (DROP_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL oob_drop2 got %0d", drop_count); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_clr got %b exp 0", err_oob); end
    wr_valid = 1'b1; wr_x = 16'd400; wr_y = 16'd5; err_clr = 1'b1;
    tick;
    wr_valid = 1'b0; err_clr = 1'b0;
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_set_wins got %b exp 1", err_oob); end
    checks++; if (drop_count !== (DROP_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL oob_drop3 got %0d", drop_count); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    wr_valid = 1'b1; wr_x = 16'd319; wr_y = 16'd239; wr_color = 16'h5A5A;
    tick;
    wr_valid = 1'b0;
    tick;
    checks++; if (mem_addr !== 20'd76799) begin errors++; $display("FAIL oob_corner_addr got %0d exp 76799", mem_addr); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_corner_flag got %b exp 0", err_oob); end
    tick;
  endtask

  task automatic test_frame_flush;
    int fl = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_x = 16'(10 + i); wr_y = 16'd0;
      tick;
    end
    wr_valid = 1'b0;
    tick;
    tick;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (frame_flushed) fl++;
      tick;
    end
    checks++; if (fl != 0) begin errors++; $display("FAIL ff_held got %0d exp 0", fl); end
    mem_ready = 1'b1;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL ff_pop1 got %b exp 0", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL ff_pop2 got %b exp 0", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL ff_pop3 got %b exp 0", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b1) begin errors++; $display("FAIL ff_pulse got %b exp 1", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL ff_single got %b exp 0", frame_flushed); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL ff_empty got %b exp 0", mem_valid); end
    mem_ready = 1'b0;
    frame_done = 1'b1;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL ff_empty_n got %b exp 0", frame_flushed); end
    tick;
    frame_done = 1'b0;
    checks++; if (frame_flushed !== 1'b1) begin errors++; $display("FAIL ff_empty_n1 got %b exp 1", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL ff_empty_n2 got %b exp 0", frame_flushed); end
  endtask

  task automatic test_after_marker;
    mem_ready = 1'b0;
    wr_valid = 1'b1; wr_x = 16'd1; wr_y = 16'd3;
    tick;
    wr_valid = 1'b0;
    tick;
    tick;
    frame_done = 1'b1; wr_valid = 1'b1; wr_x = 16'd2;
    tick;
    frame_done = 1'b0; wr_x = 16'd3;
    tick;
    wr_valid = 1'b0;
    tick;
    tick;
    mem_ready = 1'b1;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL am_p0 got %b exp 0", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b0) begin errors++; $display("FAIL am_p1 got %b exp 0", frame_flushed); end
    tick;
    checks++; if (frame_flushed !== 1'b1) begin errors++; $display("FAIL am_pulse got %b exp 1", frame_flushed); end
    checks++; if (mem_addr !== 20'd963) begin errors++; $display("FAIL am_late_head got %0d exp 963", mem_addr); end
    tick;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL am_drained got %b exp 0", mem_valid); end
    mem_ready = 1'b0;
  endtask

  task automatic test_frame_ovr;
    int fl = 0;
    mem_ready = 1'b0;
    wr_valid = 1'b1; wr_x = 16'd7; wr_y = 16'd7;
    tick;
    wr_valid = 1'b0;
    tick;
    tick;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    checks++; if (err_frame_ovr !== 1'b0) begin errors++; $display("FAIL ovr_first got %b exp 0", err_frame_ovr); end
    tick;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    checks++; if (err_frame_ovr !== 1'b1) begin errors++; $display("FAIL ovr_second got %b exp 1", err_frame_ovr); end
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (frame_flushed) fl++;
      tick;
    end
    checks++; if (fl != 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", fl); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++; if (err_frame_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", err_frame_ovr); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int fl = 0;
    int beats = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_x = 16'(20 + i); wr_y = 16'd0;
      tick;
    end
    wr_x = 16'd999;
    tick;
    wr_valid = 1'b0;
    tick;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    tick;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b exp 1", mem_valid); end
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL rm_pre_oob got %b exp 1", err_oob); end
    #3;
    Reset_n = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got %b exp 0", mem_valid); end
    tick;
    tick;
    Reset_n = 1'b1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", wr_ready); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL rm_oob got %b exp 0", err_oob); end
    checks++; if (err_frame_ovr !== 1'b0) begin errors++; $display("FAIL rm_ovr got %b exp 0", err_frame_ovr); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rm_drop got %0d exp 0", drop_count); end
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (frame_flushed) fl++;
      if (mem_valid) beats++;
      tick;
    end
    checks++; if (fl != 0) begin errors++; $display("FAIL rm_flushed got %0d exp 0", fl); end
    checks++; if (beats != 0) begin errors++; $display("FAIL rm_beats got %0d exp 0", beats); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_oob();
    test_frame_flush();
    test_after_marker();
    test_frame_ovr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
